// File: rtl/fifo_push_arbiter_pkg.sv
// Shared configuration for the FIFO push-side arbitration logic:
// default sizes, index-width helper, FSM state type and burst counter type.
package fifo_config;

    localparam int DATA_WIDTH = 8;
    localparam int NUM_REQ    = 4;
    localparam int MAX_BURST  = 4;

    // Width of an index into n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W   = idx_width(NUM_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef logic [BURST_W-1:0] burst_cnt_t;

endpackage

// File: rtl/fifo_push_arbiter_chk.sv
// Property checker for the push arbiter: grant shape, full/push exclusion,
// busy/grant consistency and the requester data-hold protocol.
module fifo_push_arbiter_chk #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = fifo_config::DATA_WIDTH
) (
    input logic                  clk,
    input logic                  res,
    input logic [NUM_REQ-1:0]    req,
    input logic [DATA_WIDTH-1:0] req_data [NUM_REQ],
    input logic [NUM_REQ-1:0]    gnt,
    input logic                  fifo_push,
    input logic                  fifo_full,
    input logic                  busy
);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!res) $onehot0(gnt));

    a_push_not_full: assert property (@(posedge clk) disable iff (!res) fifo_push |-> !fifo_full);

    a_busy_gnt: assert property (@(posedge clk) disable iff (!res) busy == (|gnt));

    // A stalled granted word must stay put until it is accepted or withdrawn.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
        a_data_hold: assert property (@(posedge clk) disable iff (!res)
            (req[i] && gnt[i] && fifo_full) |=> (!req[i] || $stable(req_data[i])));
    end

endmodule

// File: rtl/fifo_push_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first set request strictly
// after last_owner_i, wrapping to index 0. Shared by push and pull schedulers.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PICK_W  = fifo_config::idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PICK_W-1:0]  last_owner_i,
    output logic               found_o,
    output logic [PICK_W-1:0]  next_idx_o
);
    import fifo_config::*;

    // Scan candidates last_owner+1 .. last_owner+NUM_REQ (mod NUM_REQ); first hit wins.
    always_comb begin
        int                cand;
        logic [PICK_W-1:0] cand_idx;
        logic              hit;
        found_o    = 1'b0;
        next_idx_o = '0;
        cand       = 0;
        cand_idx   = '0;
        hit        = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand       = (int'(last_owner_i) + k) % NUM_REQ;
            cand_idx   = cand[PICK_W-1:0];
            hit        = req_i[cand_idx] & ~found_o;
            next_idx_o = hit ? cand_idx : next_idx_o;
            found_o    = found_o | hit;
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NUM_REQ requesters,
// with a MAX_BURST fairness limit applied only while others are waiting.
module fifo_push_arbiter #(
    parameter int   NUM_REQ    = 4,
    parameter int   DATA_WIDTH = fifo_config::DATA_WIDTH,
    parameter int   MAX_BURST  = 4,
    localparam int  OWNER_W    = fifo_config::idx_width(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [DATA_WIDTH-1:0] req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  fifo_push,
    output logic [DATA_WIDTH-1:0] fifo_din,
    input  logic                  fifo_full,
    output logic                  busy,
    output logic [OWNER_W-1:0]    owner
);
    import fifo_config::*;

    localparam int BURST_W = $clog2(MAX_BURST + 1);

    arb_state_t           state_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [OWNER_W-1:0]   owner_q;
    logic [OWNER_W-1:0]   last_q;
    logic [BURST_W-1:0]   burst_q;

    logic                 pick_found_s;
    logic [OWNER_W-1:0]   pick_idx_s;
    logic [NUM_REQ-1:0]   onehot_s;
    logic                 own_req_s;
    logic                 own_ack_s;
    logic                 others_s;
    logic [BURST_W-1:0]   burst_inc_s;
    logic                 burst_hit_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PICK_W  (OWNER_W)
    ) u_picker (
        .req_i        (req),
        .last_owner_i (last_q),
        .found_o      (pick_found_s),
        .next_idx_o   (pick_idx_s)
    );

    // Decode the picked index into the one-hot grant loaded on arbitration.
    always_comb begin
        onehot_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            onehot_s[i] = (pick_idx_s == OWNER_W'(i));
        end
    end

    // Accept a word only from the granted requester and only when the FIFO has room.
    always_comb begin
        ack         = gnt_q & req & {NUM_REQ{~fifo_full}};
        own_req_s   = req[owner_q];
        own_ack_s   = ack[owner_q];
        others_s    = |(req & ~gnt_q);
        burst_inc_s = burst_q + BURST_W'(1);
        burst_hit_s = (burst_inc_s == BURST_W'(MAX_BURST));
    end

    // Route the owner's data to the FIFO while busy; drive zero when idle.
    always_comb begin
        if (state_q == ARB_BUSY) begin
            fifo_din = req_data[owner_q];
        end else begin
            fifo_din = '0;
        end
    end

    assign fifo_push = |ack;
    assign gnt       = gnt_q;
    assign busy      = (state_q == ARB_BUSY);
    assign owner     = owner_q;

    // Arbitration FSM: grant on IDLE, count accepted pushes, release on drop or burst limit.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            burst_q <= '0;
            last_q  <= OWNER_W'(NUM_REQ - 1);
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_found_s) begin
                        state_q <= ARB_BUSY;
                        gnt_q   <= onehot_s;
                        owner_q <= pick_idx_s;
                        last_q  <= pick_idx_s;
                        burst_q <= '0;
                    end else begin
                        state_q <= ARB_IDLE;
                        gnt_q   <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (!own_req_s) begin
                        state_q <= ARB_IDLE;
                        gnt_q   <= '0;
                        burst_q <= '0;
                    end else if (own_ack_s) begin
                        if (burst_hit_s) begin
                            burst_q <= '0;
                            if (others_s) begin
                                state_q <= ARB_IDLE;
                                gnt_q   <= '0;
                            end else begin
                                state_q <= ARB_BUSY;
                            end
                        end else begin
                            burst_q <= burst_inc_s;
                        end
                    end else begin
                        burst_q <= burst_q;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    gnt_q   <= '0;
                    burst_q <= '0;
                end
            endcase
        end
    end

    fifo_push_arbiter_chk #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_chk (
        .clk       (clk),
        .res       (res),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .fifo_push (fifo_push),
        .fifo_full (fifo_full),
        .busy      (busy)
    );

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a behavioural model.
module tb_fifo_push_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          res = 1'b0;
    logic [N-1:0]  req;
    logic [DW-1:0] req_data [N];
    logic [N-1:0]  gnt;
    logic [N-1:0]  ack;
    logic          fifo_push;
    logic [DW-1:0] fifo_din;
    logic          fifo_full;
    logic          busy;
    logic [IW-1:0] owner;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state: who holds the grant, how many words it pushed, who went last.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_last  = N - 1;
    int m_cnt   = 0;
    logic [N-1:0] hold_v = '0;

    always #5 clk = ~clk;

    fifo_push_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .res       (res),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .ack       (ack),
        .fifo_push (fifo_push),
        .fifo_din  (fifo_din),
        .fifo_full (fifo_full),
        .busy      (busy),
        .owner     (owner)
    );

    // Model: round-robin grant from last owner, count accepted words, release on drop/limit.
    always @(posedge clk or negedge res) begin
        int pick;
        int others;
        if (!res) begin
            m_busy  <= 1'b0;
            m_owner <= 0;
            m_last  <= N - 1;
            m_cnt   <= 0;
        end else if (!m_busy) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                if (pick < 0 && req[(m_last + k) % N]) pick = (m_last + k) % N;
            end
            if (pick >= 0) begin
                m_busy  <= 1'b1;
                m_owner <= pick;
                m_last  <= pick;
                m_cnt   <= 0;
            end
        end else if (!req[m_owner]) begin
            m_busy <= 1'b0;
        end else if (!fifo_full) begin
            others = 0;
            for (int j = 0; j < N; j++) begin
                if (j != m_owner && req[j]) others = others + 1;
            end
            if (m_cnt + 1 == MB) begin
                m_cnt <= 0;
                if (others > 0) m_busy <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Compare DUT outputs to the model every falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_ack;
        logic          e_push;
        logic [DW-1:0] e_din;
        e_gnt  = m_busy ? (N'(1) << m_owner) : '0;
        e_ack  = e_gnt & req & {N{~fifo_full}};
        e_push = |e_ack;
        e_din  = m_busy ? req_data[m_owner] : '0;
        hold_v = e_gnt & req & {N{fifo_full}};
        n_vec++;
        if (gnt !== e_gnt || ack !== e_ack || fifo_push !== e_push || fifo_din !== e_din ||
            busy !== m_busy || (m_busy && owner !== IW'(m_owner))) begin
            n_err++;
            $display("FAIL model @%0t: gnt=%b/%b ack=%b/%b push=%b/%b din=%h/%h busy=%b/%b owner=%0d/%0d (got/expected)",
                     $time, gnt, e_gnt, ack, e_ack, fifo_push, e_push, fifo_din, e_din,
                     busy, m_busy, owner, m_owner);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] r, input logic f);
        @(posedge clk);
        #2;
        req       = r;
        fifo_full = f;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        @(posedge clk);
        #3;
        res       = 1'b0;
        req       = r;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        res = 1'b1;
    endtask

    initial begin
        int cnt;
        logic [N-1:0] exp_g;
        req       = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) req_data[i] = DW'(8'h10 + i);
        repeat (3) @(posedge clk);
        sample();
        chk("rst_gnt",   32'(gnt),       32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_owner", 32'(owner),     32'h0);
        chk("rst_push",  32'(fifo_push), 32'h0);
        chk("rst_din",   32'(fifo_din),  32'h0);

        // Single requester: one-cycle grant latency, then a push every cycle.
        req_data[0] = 8'hA5;
        do_reset(4'b0000);
        drive(4'b0001, 1'b0);
        sample();
        chk("s1_latency_gnt", 32'(gnt), 32'h0);
        repeat (6) begin
            sample();
            chk("s1_gnt",  32'(gnt),       32'h1);
            chk("s1_push", 32'(fifo_push), 32'h1);
            chk("s1_din",  32'(fifo_din),  32'hA5);
        end
        drive(4'b0000, 1'b0);
        repeat (2) sample();
        chk("s1_release_busy", 32'(busy), 32'h0);

        // All four requesting: 4 pushes per owner, one idle bubble, strict rotation.
        do_reset(4'b1111);
        @(posedge clk);
        cnt = 0;
        for (int c = 0; c < 25; c++) begin
            sample();
            exp_g = ((c % 5) == 4) ? 4'b0000 : (4'b0001 << ((c / 5) % 4));
            chk("s2_rotation_gnt", 32'(gnt), 32'(exp_g));
            if (fifo_push) cnt++;
        end
        chk("s2_push_total", 32'(cnt), 32'd20);

        // Lone requester 2: never released by the burst limit.
        do_reset(4'b0000);
        drive(4'b0100, 1'b0);
        @(posedge clk);
        cnt = 0;
        repeat (10) begin
            sample();
            chk("s3_gnt_held", 32'(gnt), 32'h4);
            if (fifo_push) cnt++;
        end
        drive(4'b0000, 1'b0);
        chk("s3_push_total", 32'(cnt), 32'd10);

        // Owner 1 stalled by full: grant held, no pushes, then its remaining 4 words.
        do_reset(4'b0000);
        drive(4'b0010, 1'b1);
        drive(4'b0011, 1'b1);
        repeat (6) begin
            sample();
            chk("s4_full_gnt",  32'(gnt),       32'h2);
            chk("s4_full_push", 32'(fifo_push), 32'h0);
        end
        drive(4'b0011, 1'b0);
        repeat (4) begin
            sample();
            chk("s4_drain_gnt",  32'(gnt),       32'h2);
            chk("s4_drain_push", 32'(fifo_push), 32'h1);
        end
        sample();
        chk("s4_bubble", 32'(gnt), 32'h0);
        sample();
        chk("s4_next_owner", 32'(gnt), 32'h1);
        drive(4'b0000, 1'b0);

        // Asynchronous reset mid-burst, then first grant after reset.
        do_reset(4'b1111);
        @(posedge clk);
        sample();
        sample();
        #2;
        res = 1'b0;
        #1;
        chk("s5_async_gnt",  32'(gnt),       32'h0);
        chk("s5_async_busy", 32'(busy),      32'h0);
        chk("s5_async_push", 32'(fifo_push), 32'h0);
        req = 4'b1000;
        @(posedge clk);
        #2;
        res = 1'b1;
        @(posedge clk);
        sample();
        chk("s5_first_gnt3", 32'(gnt), 32'h8);
        drive(4'b0001, 1'b0);
        repeat (3) sample();
        chk("s5_pre_gnt0", 32'(gnt), 32'h1);
        #2;
        res = 1'b0;
        req = 4'b1001;
        @(posedge clk);
        #2;
        res = 1'b1;
        @(posedge clk);
        sample();
        chk("s5_last_owner_reset", 32'(gnt), 32'h1);

        // One-cycle request pulse: released at the next edge, at most one push.
        do_reset(4'b0000);
        drive(4'b0001, 1'b0);
        drive(4'b0000, 1'b0);
        cnt = 0;
        repeat (3) begin
            sample();
            if (fifo_push) cnt++;
        end
        chk("s6_push_at_most_1", 32'(cnt <= 1), 32'h1);
        chk("s6_busy",           32'(busy),     32'h0);
        chk("s6_gnt",            32'(gnt),      32'h0);

        // Randomized traffic with occasional full, drops and asynchronous reset pulses.
        do_reset(4'b0000);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (!hold_v[i] && $urandom_range(0, 3) == 0) req_data[i] = DW'($urandom);
                if (req[i]) begin
                    if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
                end else begin
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
                end
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #1;
                res = 1'b0;
                #1;
                res = 1'b1;
            end
        end
        req       = '0;
        fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
Round-robin arbiter that shares the push side of one FIFO among NUM_REQ requesters.
- Grants one requester at a time and muxes its data onto fifo_din.
- Drives fifo_push only when the FIFO is not full.
- Enforces a MAX_BURST fairness limit while other requesters wait.
- Sits between producer agents/blocks and the FIFO's push/din/full pins; the pull side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, fifo_config::DATA_WIDTH, FIFO data width.
- MAX_BURST, 4, max accepted pushes per grant when another requester is pending (>=1).

Ports:
- clk  input  1  clock, all state on posedge.
- res  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester push request, level, held until done.
- req_data  input  NUM_REQ x DATA_WIDTH (unpacked array)  per-requester data.
- gnt  output  NUM_REQ  one-hot registered grant (all zero when idle).
- ack  output  NUM_REQ  combinational; ack[i] = gnt[i] & req[i] & !fifo_full; word accepted at this posedge.
- fifo_push  output  1  = |ack.
- fifo_din  output  DATA_WIDTH  req_data[owner] while busy, else 0.
- fifo_full  input  1  FIFO full flag.
- busy  output  1  grant active.
- owner  output  IDX_W  index of granted requester (valid when busy).

Behaviour:
Reset (res low, any time, asynchronous):
- state=IDLE; gnt=0; busy=0; owner=0; burst_cnt=0; last_owner=NUM_REQ-1 (requester 0 wins first).
- ack, fifo_push, fifo_din are therefore 0.
- Reset mid-burst drops the grant immediately; no push is issued during reset.

States:
- IDLE: if |req at posedge, pick the first set req index searching from last_owner+1 with wrap to 0.
  - Set gnt one-hot, owner, busy=1, burst_cnt=0, last_owner=picked, go BUSY.
  - Grant is visible the cycle after req rises (1-cycle arbitration latency).
- BUSY: each posedge with ack[owner]=1 increments burst_cnt (saturating at MAX_BURST).
  - Release to IDLE (gnt=0, busy=0) at posedge when either:
    - (a) req[owner]==0, or
    - (b) an accepted push makes burst_cnt reach MAX_BURST and any other req[j], j!=owner, is set.
  - If (b) holds but no other requester is pending, stay BUSY and reset burst_cnt to 0.
- Every release costs exactly one IDLE bubble cycle before the next grant.

Boundary conditions:
- fifo_full=1: ack/fifo_push are forced 0, burst_cnt is frozen, and the grant is held. Full never causes release.
- Owner drops req in the same cycle as full: release per (a).
- Simultaneous requests: strict rotation from last_owner. A requester re-requesting right after its own release loses to any other pending requester.
- NUM_REQ=1: degenerates to a pass-through with a 1-cycle grant latency; rule (b) never fires.
- Requesters must not change req_data while req & gnt & fifo_full. A protocol assertion checks this.

Assertions:
- gnt is one-hot0.
- fifo_push implies !fifo_full.
- busy == |gnt.

Decomposition:
- Add to fifo_config package:
  - IDX_W = $clog2(NUM_REQ) (min 1).
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t.
  - typedef for the burst counter width $clog2(MAX_BURST+1).
- One sub-module, rr_picker: combinational, inputs req and last_owner; outputs found and next index.
  - Reusable for the later pull-side scheduler.
- Counter and FSM live in the top module.

Test Plan:
- Reset then req=4'b0001, fifo_full=0, req_data[0]=8'hA5 → gnt=0001 one cycle later; fifo_push=1 and fifo_din=A5 each cycle while req[0] is held.
- req=4'b1111 from reset, always held, MAX_BURST=4, never full → grants in order 0,1,2,3,0. Each grant gives exactly 4 pushes, followed by 1 idle cycle (5-cycle period per owner).
- Owner 2 alone, MAX_BURST=4, 10 pushes → grant is never released; exactly 10 acks, no bubbles.
- Owner 1 granted, fifo_full=1 for 6 cycles while req=4'b0011 → fifo_push=0, gnt stays 0010, burst_cnt frozen.
  - After full drops, owner 1 gets its remaining pushes up to 4 total, then the grant passes to 0.
- Assert res low while busy mid-burst → gnt, busy, fifo_push go 0 asynchronously.
  - After release with req=4'b1000, the first grant goes to 3. With req=4'b1001, it goes to 0 (last_owner reset to NUM_REQ-1).
- req[0] pulsed 1 cycle then dropped while granted → grant released next posedge; at most 1 push issued; busy returns 0.
